// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, falling-edge start detect, centre sampling.
// Define UART_RX_PARITY_EN to add a parity bit (even, or odd with PARITY_ODD=1) before the stop bit.
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       sysclk,
  input  logic       nrst,
  input  logic       rs232_rx,
  output logic [7:0] dataout,
  output logic       rx_done,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int BAUD_CNT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = $clog2(BAUD_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(BAUD_CNT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             sync1;
  logic             sync2;
  logic             sync3;
  logic             rx_s;
  logic             rx_fall;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             sample_tick;
  logic             stop_sample;
  logic             par_bad;
  logic             done_set;
  logic             ferr_set;
  logic             perr_set;

  assign rx_s    = sync2;
  assign rx_fall = sync3 & ~sync2;

  always_ff @(posedge sysclk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // START waits half a bit to the start-bit centre; from there every later
  // state waits one full bit, which lands each sample on its bit centre.
  always_comb begin
    sample_tick = 1'b0;
    if (state == START) begin
      sample_tick = (clk_cnt == CNT_MID);
    end else if (state != IDLE) begin
      sample_tick = (clk_cnt == CNT_MAX);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (rx_fall) next_state = START;
      START: if (sample_tick) next_state = rx_s ? IDLE : DATA;
      DATA: begin
        if (sample_tick && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (sample_tick) next_state = STOP;
`endif
      STOP:  if (sample_tick) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic parity_bit;

  always_ff @(posedge sysclk or negedge nrst) begin
    if (!nrst) begin
      parity_bit <= 1'b0;
    end else if (state == PARITY && sample_tick) begin
      parity_bit <= rx_s;
    end
  end

  assign par_bad = parity_bit != ((^shift_reg) ^ PARITY_ODD);
`else
  assign par_bad = 1'b0;
`endif

  // A low stop bit wins over a parity mismatch, so the three pulses never overlap.
  always_comb begin
    stop_sample = (state == STOP) && sample_tick;
    done_set    = stop_sample && rx_s && !par_bad;
    ferr_set    = stop_sample && !rx_s;
    perr_set    = stop_sample && rx_s && par_bad;
  end

  always_ff @(posedge sysclk or negedge nrst) begin
    if (!nrst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= rs232_rx;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge sysclk or negedge nrst) begin
    if (!nrst) begin
      clk_cnt <= '0;
    end else if (state != next_state || clk_cnt == CNT_MAX) begin
      clk_cnt <= '0;
    end else if (state != IDLE) begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

  always_ff @(posedge sysclk or negedge nrst) begin
    if (!nrst) begin
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else if (state != DATA) begin
      bit_idx <= 3'd0;
    end else if (sample_tick) begin
      bit_idx   <= bit_idx + 3'd1;
      shift_reg <= {rx_s, shift_reg[7:1]};
    end
  end

  always_ff @(posedge sysclk or negedge nrst) begin
    if (!nrst) begin
      dataout   <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= done_set;
      frame_err <= ferr_set;
      if (done_set) begin
        dataout <= shift_reg;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sysclk or negedge nrst) begin
    if (!nrst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= perr_set;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
